wm_init_dump_ctrl: RTL
======================

# wm_init_dump_ctrl

Sequencer that owns the Working Memory write port and the Output Memory write port outside the relaxation phase of the Bellman-Ford engine. On `start_init` it reads the source node ID from Input Memory address 0 and writes every Working Memory distance row: all lanes INF except the source lane, which is 0. On `start_dump` it copies Working Memory rows verbatim into Output Memory. While `busy` is high, the relaxation engine must not drive the Working Memory or Output Memory write ports.

## Interface
Parameters:
- `NUM_ROWS`, default 32: 128-bit distance rows; 8 lanes per row, so it covers 8·NUM_ROWS nodes; legal range 1..32.
- `INF`, default 16'hFFFF: 16-bit "unreached" distance value.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start_init`  in  1  one-cycle request to initialise Working Memory.
- `start_dump`  in  1  one-cycle request to copy Working Memory to Output Memory.
- `IMAR`  out  13  Input Memory read address; constant 0.
- `IMDR`  in  8  Input Memory read data (source node ID), combinational.
- `WMAR1`  out  13  Working Memory read address 1.
- `WMDR1`  in  128  Working Memory read data 1, combinational.
- `WMWAR`  out  13  Working Memory write address.
- `WMWDR`  out  128  Working Memory write data.
- `WMWE`  out  1  Working Memory write enable.
- `OMWAR`  out  13  Output Memory write address.
- `OMWDR`  out  128  Output Memory write data.
- `OMWE`  out  1  Output Memory write enable.
- `busy`  out  1  high in every state except IDLE.
- `init_done`  out  1  one-cycle pulse when initialisation finishes.
- `dump_done`  out  1  one-cycle pulse when the dump finishes.
- `src_err`  out  1  source ID was ≥ 8·NUM_ROWS; held until the next accepted start.

## Operation
- States: IDLE, FETCH, INIT, DUMP.
- Reset value of every output is 0, including `IMAR` and the address and data buses. State after reset is IDLE, and the row counter is 0.
- IDLE:
  - `start_init` → FETCH, and `src_err` is cleared.
  - Otherwise `start_dump` → DUMP, `row`=0, and `src_err` is cleared.
  - Both high together: init wins and the dump request is dropped.
  - Starts that arrive in any non-IDLE state are ignored and are not queued.
- FETCH (1 cycle):
  - `src_reg` ← `IMDR`.
  - `src_err` ← (IMDR ≥ 8·NUM_ROWS).
  - `row` ← 0, then → INIT.
- INIT (NUM_ROWS cycles):
  - `WMWE`=1 and `WMWAR`=`row`.
  - Lane k is `WMWDR[16k+15:16k]`.
  - Every lane = INF, except lane `src_reg[2:0]` of row `src_reg[7:3]`, which = 16'h0000. The exception does not apply when `src_err` is set.
  - On `row`==NUM_ROWS-1: → IDLE and pulse `init_done`. Otherwise `row`+1.
- DUMP (NUM_ROWS cycles):
  - `WMAR1`=`row`, `OMWAR`=`row`, `OMWDR`=`WMDR1` (combinational pass-through), `OMWE`=1.
  - On `row`==NUM_ROWS-1: → IDLE and pulse `dump_done`. Otherwise `row`+1.
- Write enables and addresses are decoded from registered state and `row`. Outside INIT, `WMWE`=0; outside DUMP, `OMWE`=0. In IDLE, `WMWAR`, `WMWDR`, `OMWAR`, `OMWDR` and `WMAR1` are driven to 0.
- `row` is 13 bits. It never exceeds NUM_ROWS-1, so no wrap-around case exists.
- Reset mid-INIT or mid-DUMP aborts immediately:
  - Next state is IDLE, and both write enables are 0 from the cycle after the reset edge.
  - No done pulse is produced. Partially written memory is left as is.

## Timing
- `start_init` sampled at edge 0:
  - FETCH occupies cycle 1.
  - Writes to rows 0..NUM_ROWS-1 occupy cycles 2..NUM_ROWS+1.
  - `init_done` is high in cycle NUM_ROWS+2, while state is IDLE and `busy`=0.
  - Total latency is NUM_ROWS+2 cycles.
- `start_dump` sampled at edge 0:
  - Copies occupy cycles 1..NUM_ROWS.
  - `dump_done` is high in cycle NUM_ROWS+1.
- `busy` rises in the cycle after the accepted start. It falls in the same cycle that the done pulse rises.
- A new start is accepted in the same cycle as the done pulse, because state is IDLE.

## Test plan
- IMDR=8'd10, NUM_ROWS=32, `start_init` pulse → 32 WM writes at cycles 2..33. Row 1 = 128'hFFFF…FFFF with bits [47:32]=0. All other rows are all-F. `init_done` at cycle 34; `src_err`=0.
- IMDR=8'd0 → row 0 lane 0 = 0, i.e. row 0 = {112'hFF…F, 16'h0000}. IMDR=8'd255 → row 31 lane 7 = 0, i.e. bits [127:112] of row 31.
- NUM_ROWS=4, IMDR=8'd40 → all 4 rows written all-INF, `src_err`=1, `init_done` at cycle 6.
- Preload WM row r = {8{r[15:0]}}, `start_dump` → OM rows 0..31 match WM exactly. `OMWE` is high in cycles 1..32; `dump_done` in cycle 33.
- `start_init` and `start_dump` in the same cycle → only the init runs and no dump occurs. A `start_dump` issued mid-INIT is ignored.
- `reset` asserted during INIT at row 5 → `WMWE`=0 from the next cycle, no `init_done` pulse, and all outputs return to 0.

Source files
------------

// File: rtl/wm_init_dump_ctrl_if.sv
// Memory-side bus of the init/dump sequencer: Input Memory read port,
// Working Memory read/write ports and Output Memory write port.
interface wm_init_dump_ctrl_if;
    logic [12:0]  IMAR;
    logic [7:0]   IMDR;
    logic [12:0]  WMAR1;
    logic [127:0] WMDR1;
    logic [12:0]  WMWAR;
    logic [127:0] WMWDR;
    logic         WMWE;
    logic [12:0]  OMWAR;
    logic [127:0] OMWDR;
    logic         OMWE;

    modport master (
        output IMAR,
        input  IMDR,
        output WMAR1,
        input  WMDR1,
        output WMWAR,
        output WMWDR,
        output WMWE,
        output OMWAR,
        output OMWDR,
        output OMWE
    );

    modport slave (
        input  IMAR,
        output IMDR,
        input  WMAR1,
        output WMDR1,
        input  WMWAR,
        input  WMWDR,
        input  WMWE,
        input  OMWAR,
        input  OMWDR,
        input  OMWE
    );
endinterface

// File: rtl/wm_init_dump_ctrl.sv
// Owns the Working/Output Memory write ports outside relaxation: fills every
// distance row with INF (source lane 0) on start_init, copies WM to OM on start_dump.
module wm_init_dump_ctrl #(
    parameter int          NUM_ROWS = 32,
    parameter logic [15:0] INF      = 16'hFFFF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_init,
    input  logic                 start_dump,
    wm_init_dump_ctrl_if.master  mem,
    output logic                 busy,
    output logic                 init_done,
    output logic                 dump_done,
    output logic                 src_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        INIT,
        DUMP
    } state_t;

    localparam logic [12:0] LAST_ROW  = 13'(NUM_ROWS - 1);
    localparam logic [9:0]  NUM_NODES = 10'(8 * NUM_ROWS);

    state_t       state_reg;
    logic [12:0]  row_reg;
    logic [7:0]   src_reg;
    logic         src_err_reg;
    logic         init_done_reg;
    logic         dump_done_reg;
    logic         last_row;
    logic         row_hit;
    logic [127:0] init_row;

    assign last_row = (row_reg == LAST_ROW);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            src_reg       <= '0;
            src_err_reg   <= 1'b0;
            init_done_reg <= 1'b0;
            dump_done_reg <= 1'b0;
        end else begin
            init_done_reg <= 1'b0;
            dump_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // init has priority; a simultaneous dump request is dropped
                    if (start_init) begin
                        state_reg   <= FETCH;
                        src_err_reg <= 1'b0;
                    end else if (start_dump) begin
                        state_reg   <= DUMP;
                        row_reg     <= '0;
                        src_err_reg <= 1'b0;
                    end
                end
                FETCH: begin
                    src_reg     <= mem.IMDR;
                    src_err_reg <= ({2'b00, mem.IMDR} >= NUM_NODES);
                    row_reg     <= '0;
                    state_reg   <= INIT;
                end
                INIT: begin
                    if (last_row) begin
                        state_reg     <= IDLE;
                        row_reg       <= '0;
                        init_done_reg <= 1'b1;
                    end else begin
                        row_reg <= row_reg + 13'd1;
                    end
                end
                DUMP: begin
                    if (last_row) begin
                        state_reg     <= IDLE;
                        row_reg       <= '0;
                        dump_done_reg <= 1'b1;
                    end else begin
                        row_reg <= row_reg + 13'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // An out-of-range source leaves every lane at INF.
    assign row_hit = !src_err_reg && (row_reg == {8'd0, src_reg[7:3]});

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        assign init_row[16*gi +: 16] = (row_hit && (src_reg[2:0] == 3'(gi))) ? 16'h0000 : INF;
    end

    always_comb begin
        mem.WMAR1 = '0;
        mem.WMWAR = '0;
        mem.WMWDR = '0;
        mem.WMWE  = 1'b0;
        mem.OMWAR = '0;
        mem.OMWDR = '0;
        mem.OMWE  = 1'b0;
        case (state_reg)
            INIT: begin
                mem.WMWE  = 1'b1;
                mem.WMWAR = row_reg;
                mem.WMWDR = init_row;
            end
            DUMP: begin
                mem.WMAR1 = row_reg;
                mem.OMWAR = row_reg;
                mem.OMWDR = mem.WMDR1;
                mem.OMWE  = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem.IMAR  = '0;
    assign busy      = (state_reg != IDLE);
    assign init_done = init_done_reg;
    assign dump_done = dump_done_reg;
    assign src_err   = src_err_reg;

endmodule
